data_memory: RTL and testbench

Global data memory responder on the far end of the data controller's memory-side interface. Exposes MAX_THREADS independent lanes, each accepting one read or write request at a time over valid/ready, modelling a fixed access latency, and returning read data (valid/ready) or a one-cycle write acknowledge. All lanes share a single storage array. The controller holds request valid high until its core finishes; each lane therefore services a held-high request exactly once.

---
 rtl/data_memory.sv | 139 +++++++++++++
 tb/tb_data_memory.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Multi-lane data memory responder: per-lane request FSM, fixed latency, shared array.
// Optional out-of-range checking is enabled with DATA_MEM_ADDR_CHECK_EN.
//   state   | meaning
//   IDLE    | ready for a read or write request
//   RD_WAIT | read accepted, latency counter running
//   RD_RESP | read data presented until the requester takes it
//   WR_WAIT | write committed, latency counter running
//   WR_RESP | one-cycle write acknowledge
//   HOLD    | response done, waiting for the requester to drop valid
module data_memory #(
    parameter int MAX_THREADS    = 4,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 16,
    parameter int MEM_DEPTH      = 256,
    parameter int MEM_LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      read_req_rdy   [MAX_THREADS],
    input  logic [MEM_ADDR_WIDTH-1:0] read_req_addr  [MAX_THREADS],
    input  logic                      read_req_val   [MAX_THREADS],
    input  logic                      read_resp_rdy  [MAX_THREADS],
    output logic [MEM_DATA_WIDTH-1:0] read_resp_data [MAX_THREADS],
    output logic                      read_resp_val  [MAX_THREADS],
    output logic                      write_req_rdy  [MAX_THREADS],
    input  logic [MEM_ADDR_WIDTH-1:0] write_req_addr [MAX_THREADS],
    input  logic [MEM_DATA_WIDTH-1:0] write_req_data [MAX_THREADS],
    input  logic                      write_req_val  [MAX_THREADS],
    output logic                      write_resp_val [MAX_THREADS],
    output logic                      addr_err
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP, HOLD
    } state_t;

    state_t                    state_q [MAX_THREADS];
    state_t                    state_d [MAX_THREADS];
    logic [CNT_W-1:0]          cnt_q   [MAX_THREADS];
    logic [MEM_ADDR_WIDTH-1:0] addr_q  [MAX_THREADS];
    logic [MEM_DATA_WIDTH-1:0] mem     [MEM_DEPTH];

    function automatic logic [IDX_W-1:0] to_idx(input logic [MEM_ADDR_WIDTH-1:0] a);
        return IDX_W'(int'(a) % MEM_DEPTH);
    endfunction

    function automatic logic in_range(input logic [MEM_ADDR_WIDTH-1:0] a);
`ifdef DATA_MEM_ADDR_CHECK_EN
        return int'(a) < MEM_DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    always_comb begin
        for (int i = 0; i < MAX_THREADS; i++) begin
            state_d[i]        = state_q[i];
            read_req_rdy[i]   = 1'b0;
            write_req_rdy[i]  = 1'b0;
            read_resp_val[i]  = 1'b0;
            write_resp_val[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    read_req_rdy[i]  = !reset;
                    write_req_rdy[i] = !reset;
                    if (read_req_val[i])       state_d[i] = RD_WAIT;
                    else if (write_req_val[i]) state_d[i] = WR_WAIT;
                end
                RD_WAIT: if (cnt_q[i] == '0) state_d[i] = RD_RESP;
                RD_RESP: begin
                    read_resp_val[i] = 1'b1;
                    if (read_resp_rdy[i]) state_d[i] = HOLD;
                end
                WR_WAIT: if (cnt_q[i] == '0) state_d[i] = WR_RESP;
                WR_RESP: begin
                    write_resp_val[i] = 1'b1;
                    state_d[i]        = HOLD;
                end
                HOLD: if (!read_req_val[i] && !write_req_val[i]) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_THREADS; i++) begin
            if (reset) begin
                state_q[i]        <= IDLE;
                cnt_q[i]          <= '0;
                addr_q[i]         <= '0;
                read_resp_data[i] <= '0;
            end else begin
                state_q[i] <= state_d[i];
                if (state_q[i] == IDLE) begin
                    if (read_req_val[i] || write_req_val[i])
                        cnt_q[i] <= CNT_W'(MEM_LATENCY - 1);
                    if (read_req_val[i])
                        addr_q[i] <= read_req_addr[i];
                end else if ((state_q[i] == RD_WAIT || state_q[i] == WR_WAIT) && cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
                // Non-blocking read of mem sees only writes committed on earlier edges.
                if (state_q[i] == RD_WAIT && cnt_q[i] == '0)
                    read_resp_data[i] <= in_range(addr_q[i]) ? mem[to_idx(addr_q[i])] : '1;
            end
        end
    end

    // Ascending lane order makes the highest-index lane win a same-edge collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_THREADS; i++) begin
            if (!reset && state_q[i] == IDLE && !read_req_val[i] && write_req_val[i]
                && in_range(write_req_addr[i]))
                mem[to_idx(write_req_addr[i])] <= write_req_data[i];
        end
    end

`ifdef DATA_MEM_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_THREADS; i++) begin
                if (state_q[i] == IDLE) begin
                    if (read_req_val[i] && !in_range(read_req_addr[i]))
                        addr_err <= 1'b1;
                    else if (!read_req_val[i] && write_req_val[i] && !in_range(write_req_addr[i]))
                        addr_err <= 1'b1;
                end
            end
        end
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: transaction-level lane model plus directed vectors.
module tb_data_memory;
    localparam int NT    = 4;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read_req_rdy   [NT];
    logic [AW-1:0] read_req_addr  [NT];
    logic          read_req_val   [NT];
    logic          read_resp_rdy  [NT];
    logic [DW-1:0] read_resp_data [NT];
    logic          read_resp_val  [NT];
    logic          write_req_rdy  [NT];
    logic [AW-1:0] write_req_addr [NT];
    logic [DW-1:0] write_req_data [NT];
    logic          write_req_val  [NT];
    logic          write_resp_val [NT];
    logic          addr_err;

    int tests = 0;
    int fails = 0;

    data_memory #(
        .MAX_THREADS(NT), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW),
        .MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .read_req_rdy(read_req_rdy), .read_req_addr(read_req_addr),
        .read_req_val(read_req_val), .read_resp_rdy(read_resp_rdy),
        .read_resp_data(read_resp_data), .read_resp_val(read_resp_val),
        .write_req_rdy(write_req_rdy), .write_req_addr(write_req_addr),
        .write_req_data(write_req_data), .write_req_val(write_req_val),
        .write_resp_val(write_resp_val), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each lane holds one transaction described by kind, accept edge and hold edge.
    int            cyc = 0;
    bit            model_on = 1'b0;
    int            m_kind [NT];   // 0 idle, 1 read, 2 write
    int            m_acc  [NT];
    int            m_hold [NT];
    logic [AW-1:0] m_addr [NT];
    logic [DW-1:0] m_data [NT];
    logic [DW-1:0] shadow [DEPTH];
    bit            m_err = 1'b0;

    function automatic bit oor(input logic [AW-1:0] a);
`ifdef DATA_MEM_ADDR_CHECK_EN
        return int'(a) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        bit was_idle [NT];
        cyc++;
        if (reset) begin
            model_on = 1'b1;
            m_err    = 1'b0;
            for (int i = 0; i < NT; i++) begin
                m_kind[i] = 0;
                m_hold[i] = NEVER;
            end
        end else if (model_on) begin
            for (int i = 0; i < NT; i++) begin
                was_idle[i] = (m_kind[i] == 0);
                if (m_kind[i] == 1) begin
                    if (cyc == m_acc[i] + LAT)
                        m_data[i] = oor(m_addr[i]) ? 16'hFFFF : shadow[int'(m_addr[i]) % DEPTH];
                    else if (cyc > m_acc[i] + LAT && m_hold[i] == NEVER && read_resp_rdy[i])
                        m_hold[i] = cyc;
                    else if (cyc > m_hold[i] && !read_req_val[i] && !write_req_val[i])
                        m_kind[i] = 0;
                end else if (m_kind[i] == 2) begin
                    if (cyc == m_acc[i] + LAT)
                        m_hold[i] = cyc + 1;
                    else if (cyc > m_hold[i] && !read_req_val[i] && !write_req_val[i])
                        m_kind[i] = 0;
                end
            end
            for (int i = 0; i < NT; i++) begin
                if (was_idle[i] && read_req_val[i]) begin
                    m_kind[i] = 1; m_acc[i] = cyc; m_hold[i] = NEVER;
                    m_addr[i] = read_req_addr[i];
                    if (oor(read_req_addr[i])) m_err = 1'b1;
                end else if (was_idle[i] && write_req_val[i]) begin
                    m_kind[i] = 2; m_acc[i] = cyc; m_hold[i] = NEVER;
                    if (oor(write_req_addr[i])) m_err = 1'b1;
                    else shadow[int'(write_req_addr[i]) % DEPTH] = write_req_data[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int i = 0; i < NT; i++) begin
                logic er, ev, ew;
                er = (m_kind[i] == 0) && !reset;
                ev = (m_kind[i] == 1) && (cyc >= m_acc[i] + LAT) && (cyc < m_hold[i]);
                ew = (m_kind[i] == 2) && (cyc == m_acc[i] + LAT);
                chk($sformatf("cmp_read_req_rdy[%0d]", i), 32'(read_req_rdy[i]), 32'(er));
                chk($sformatf("cmp_write_req_rdy[%0d]", i), 32'(write_req_rdy[i]), 32'(er));
                chk($sformatf("cmp_read_resp_val[%0d]", i), 32'(read_resp_val[i]), 32'(ev));
                chk($sformatf("cmp_write_resp_val[%0d]", i), 32'(write_resp_val[i]), 32'(ew));
                if (ev) chk($sformatf("cmp_read_resp_data[%0d]", i), 32'(read_resp_data[i]), 32'(m_data[i]));
            end
            chk("cmp_addr_err", 32'(addr_err), 32'(m_err));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < NT; i++) begin
            read_req_val[i]  = 1'b0;
            write_req_val[i] = 1'b0;
        end
        tick(3);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NT; i++) begin
            read_req_addr[i] = '0; read_req_val[i] = 1'b0; read_resp_rdy[i] = 1'b1;
            write_req_addr[i] = '0; write_req_data[i] = '0; write_req_val[i] = 1'b0;
        end
        tick(3);
        chk("reset_rdy", 32'(read_req_rdy[0]), 32'd0);
        chk("reset_rval", 32'(read_resp_val[0]), 32'd0);
        chk("reset_data", 32'(read_resp_data[2]), 32'd0);
        chk("reset_err", 32'(addr_err), 32'd0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < NT; i++) chk($sformatf("post_reset_rdy[%0d]", i), 32'(read_req_rdy[i]), 32'd1);

        // basic write then read on lane 0
        write_req_addr[0] = 8'd5; write_req_data[0] = 16'h1234; write_req_val[0] = 1'b1;
        tick(); chk("wr_ack_n", 32'(write_resp_val[0]), 32'd0);
        tick(); chk("wr_ack_n1", 32'(write_resp_val[0]), 32'd0);
        tick(); chk("wr_ack_n2", 32'(write_resp_val[0]), 32'd1);
        tick(); chk("wr_ack_n3", 32'(write_resp_val[0]), 32'd0);
        chk("wr_hold_rdy", 32'(write_req_rdy[0]), 32'd0);
        chk("model_shadow5", 32'(shadow[5]), 32'h1234);
        write_req_val[0] = 1'b0;
        tick(); chk("wr_rdy_back", 32'(read_req_rdy[0]), 32'd1);

        // held valid read: one response only
        read_req_addr[0] = 8'd5; read_req_val[0] = 1'b1;
        tick(); chk("rd_rdy_busy", 32'(read_req_rdy[0]), 32'd0);
        tick(); chk("rd_val_n1", 32'(read_resp_val[0]), 32'd0);
        tick(); chk("rd_val_n2", 32'(read_resp_val[0]), 32'd1);
        chk("rd_data_n2", 32'(read_resp_data[0]), 32'h1234);
        n = 1;
        repeat (8) begin
            tick();
            n += int'(read_resp_val[0]);
            chk("held_rdy_low", 32'(read_req_rdy[0]), 32'd0);
        end
        chk("held_resp_count", 32'(n), 32'd1);
        read_req_val[0] = 1'b0;
        chk("held_rdy_before_drop_edge", 32'(read_req_rdy[0]), 32'd0);
        tick(); chk("held_rdy_after_drop", 32'(read_req_rdy[0]), 32'd1);

        // backpressure on lane 1
        read_req_addr[1] = 8'd5; read_req_val[1] = 1'b1; read_resp_rdy[1] = 1'b0;
        tick(3);
        chk("bp_val0", 32'(read_resp_val[1]), 32'd1);
        chk("bp_data0", 32'(read_resp_data[1]), 32'h1234);
        repeat (4) begin
            tick();
            chk("bp_val", 32'(read_resp_val[1]), 32'd1);
            chk("bp_data", 32'(read_resp_data[1]), 32'h1234);
        end
        read_resp_rdy[1] = 1'b1;
        tick(); chk("bp_done_val", 32'(read_resp_val[1]), 32'd0);
        chk("bp_hold_rdy", 32'(read_req_rdy[1]), 32'd0);
        idle_all();

        // four lanes in parallel
        for (int i = 0; i < NT; i++) begin
            write_req_addr[i] = AW'(i); write_req_data[i] = DW'(16'hA0 + i); write_req_val[i] = 1'b1;
        end
        tick(4);
        idle_all();
        for (int i = 0; i < NT; i++) begin
            read_req_addr[i] = AW'(i); read_req_val[i] = 1'b1;
        end
        tick(3);
        for (int i = 0; i < NT; i++) begin
            chk($sformatf("par_val[%0d]", i), 32'(read_resp_val[i]), 32'd1);
            chk($sformatf("par_data[%0d]", i), 32'(read_resp_data[i]), 32'(16'hA0 + i));
        end
        idle_all();

        // write collision: lane 3 wins
        write_req_addr[1] = 8'd9; write_req_data[1] = 16'h1111; write_req_val[1] = 1'b1;
        write_req_addr[3] = 8'd9; write_req_data[3] = 16'h3333; write_req_val[3] = 1'b1;
        tick(4);
        idle_all();
        chk("model_shadow9", 32'(shadow[9]), 32'h3333);
        read_req_addr[0] = 8'd9; read_req_val[0] = 1'b1;
        tick(3);
        chk("coll_data", 32'(read_resp_data[0]), 32'h3333);
        idle_all();

        // out-of-range address 70 with depth 64
        write_req_addr[2] = 8'd70; write_req_data[2] = 16'hBEEF; write_req_val[2] = 1'b1;
        tick(3); chk("oor_wr_ack", 32'(write_resp_val[2]), 32'd1);
        tick();
        idle_all();
        read_req_addr[2] = 8'd70; read_req_val[2] = 1'b1;
        tick(3);
        chk("oor_rd_val", 32'(read_resp_val[2]), 32'd1);
`ifdef DATA_MEM_ADDR_CHECK_EN
        chk("oor_rd_data", 32'(read_resp_data[2]), 32'hFFFF);
        chk("oor_err", 32'(addr_err), 32'd1);
`else
        chk("oor_rd_data", 32'(read_resp_data[2]), 32'hBEEF);
        chk("oor_err", 32'(addr_err), 32'd0);
`endif
        idle_all();
`ifndef DATA_MEM_ADDR_CHECK_EN
        read_req_addr[0] = 8'd6; read_req_val[0] = 1'b1;
        tick(3);
        chk("alias_data", 32'(read_resp_data[0]), 32'hBEEF);
        idle_all();
`endif

        // reset during RD_WAIT
        read_req_addr[0] = 8'd5; read_req_val[0] = 1'b1;
        tick(2);
        reset = 1'b1; read_req_val[0] = 1'b0;
        tick();
        chk("rst_mid_val", 32'(read_resp_val[0]), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_mid_rdy", 32'(read_req_rdy[0]), 32'd1);
        chk("rst_mid_err", 32'(addr_err), 32'd0);
        repeat (3) begin
            tick();
            chk("rst_mid_no_resp", 32'(read_resp_val[0]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
